// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: round-robin arbiter sharing the external line memory between the I-cache and D-cache refill ports
module ext_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack,
  output logic              err,
  output logic              owner
);
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic i_ack_q, i_ack_d, d_ack_q, d_ack_d, mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
  logic err_q, err_d, owner_q, owner_d;
  logic [LINE_W-1:0] rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, addr_sel;
  logic gnt, tout, done;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign rdata     = rdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign owner     = owner_q;
  // next-state: grant on a tie goes opposite the last owner; a mem_ack coinciding with the timeout wins
  always_comb begin
    gnt         = (i_req && d_req) ? ~owner_q : d_req;
    addr_sel    = gnt ? d_addr : i_addr;
    tout        = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1)) && !mem_ack;
    done        = (state_q == BUSY) && (mem_ack || tout);
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    owner_d     = owner_q;
    if (state_q == IDLE && (i_req || d_req)) begin
      state_d     = BUSY;
      owner_d     = gnt;
      cnt_d       = '0;
      mem_cs_d    = 1'b1;
      mem_we_d    = gnt & d_we;
      mem_addr_d  = {addr_sel[ADDR_W-1:5], 5'b0};
      mem_wdata_d = gnt ? d_wdata : '0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        state_d  = RESP;
        mem_cs_d = 1'b0;
        mem_we_d = 1'b0;
        i_ack_d  = ~owner_q;
        d_ack_d  = owner_q;
        err_d    = err_q | tout;
        rdata_d  = tout ? '0 : (mem_we_q ? rdata_q : mem_data_i);
      end
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  // state and registered outputs; reset aborts any transaction without an ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      owner_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      owner_q     <= owner_d;
    end
  end
endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: directed scoreboard bench for the external memory arbiter
module tb_ext_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  logic clk = 1'b0, rst = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [LW-1:0] d_wdata = '0, mem_data_i = '0;
  logic i_ack, d_ack, mem_cs, mem_we, err, owner;
  logic [LW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  typedef struct {bit port; logic [LW-1:0] rd;} exp_t;
  exp_t sb[$];
  logic [LW-1:0] last_rd = '0;
  int checks = 0, errors = 0;
  ext_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_data_i(mem_data_i), .mem_ack(mem_ack),
    .err(err), .owner(owner)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input bit port, input bit we, input logic [LW-1:0] d);
    if (!we) last_rd = d;
    sb.push_back('{port, last_rd});
  endtask
  // one transaction: lat<0 means no mem_ack (timeout); drop releases both requests at the ack
  task automatic serve(input int lat, input logic [LW-1:0] data, input logic ewe,
                       input logic [AW-1:0] eaddr, input logic [LW-1:0] ewd, input bit drop);
    int n;
    logic [AW-1:0] si, sd;
    logic [LW-1:0] sw;
    logic swe;
    exp_t e;
    n = 0;
    while (!mem_cs && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_lat", n, 1);
    check("mem_we", mem_we, ewe);
    check("mem_addr", mem_addr, eaddr);
    if (ewe) check("mem_wdata", mem_wdata, ewd);
    if (lat >= 0) begin
      si = i_addr; sd = d_addr; sw = d_wdata; swe = d_we;
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        i_addr = $urandom; d_addr = $urandom; d_wdata = {8{$urandom}}; d_we = ~d_we;
      end
      check("hold_cs", mem_cs, 1);
      check("hold_we", mem_we, ewe);
      check("hold_addr", mem_addr, eaddr);
      if (ewe) check("hold_wdata", mem_wdata, ewd);
      i_addr = si; d_addr = sd; d_wdata = sw; d_we = swe;
      mem_data_i = data; mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; mem_data_i = '0;
    end else begin
      n = 0;
      while (mem_cs && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("busy_len", n, 8);
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL sb_underflow observed=ack expected=none");
      return;
    end
    e = sb.pop_front();
    check("i_ack", i_ack, e.port == 1'b0);
    check("d_ack", d_ack, e.port == 1'b1);
    check("rdata", rdata, e.rd);
    check("owner", owner, e.port);
    check("resp_cs", mem_cs, 0);
    if (drop) begin i_req = 1'b0; d_req = 1'b0; end
    @(negedge clk);
    check("ack_pulse", {i_ack, d_ack}, 0);
    check("cs_gap", mem_cs, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [LW-1:0] a5, db, x;
    a5 = {32{8'hA5}};
    db = {8{32'hDEADBEEF}};
    repeat (3) @(negedge clk);
    check("rst_cs", mem_cs, 0);
    check("rst_we", mem_we, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_owner", owner, 1);
    rst = 1'b1;
    @(negedge clk);
    // I-only read
    i_addr = 32'h0000_1234; i_req = 1'b1; push(0, 0, a5);
    serve(5, a5, 0, 32'h0000_1220, '0, 1);
    // D write-back with requester inputs churning during BUSY
    d_we = 1'b1; d_addr = 32'h0040_0000; d_wdata = db; d_req = 1'b1; push(1, 1, '0);
    serve(3, {8{32'h1234_5678}}, 1, 32'h0040_0000, db, 1);
    d_we = 1'b0;
    // three ties alternate I, D, I
    i_addr = 32'h0000_0100; d_addr = 32'h0000_2000; i_req = 1'b1; d_req = 1'b1;
    push(0, 0, {8{32'h1111_0001}}); push(1, 0, {8{32'h2222_0002}}); push(0, 0, {8{32'h3333_0003}});
    serve(2, {8{32'h1111_0001}}, 0, 32'h0000_0100, '0, 0);
    serve(1, {8{32'h2222_0002}}, 0, 32'h0000_2000, '0, 0);
    serve(0, {8{32'h3333_0003}}, 0, 32'h0000_0100, '0, 1);
    // back-to-back D only
    d_addr = 32'h3000_005F; d_req = 1'b1;
    for (int t = 0; t < 3; t++) push(1, 0, {8{32'hC0DE_0000 + 32'(t)}});
    for (int t = 0; t < 3; t++) serve(t + 1, {8{32'hC0DE_0000 + 32'(t)}}, 0, 32'h3000_0040, '0, t == 2);
    // timeout
    i_addr = 32'h0000_0500; i_req = 1'b1; push(0, 0, '0);
    serve(-1, '0, 0, 32'h0000_0500, '0, 1);
    check("err_set", err, 1);
    // normal transaction keeps err
    x = {8{32'h0F0F_7777}};
    d_addr = 32'h0000_0600; d_req = 1'b1; push(1, 0, x);
    serve(4, x, 0, 32'h0000_0600, '0, 1);
    check("err_sticky", err, 1);
    // reset in the middle of BUSY
    d_addr = 32'h0000_0700; d_req = 1'b1;
    @(negedge clk);
    check("pre_rst_cs", mem_cs, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_cs", mem_cs, 0);
    check("async_owner", owner, 1);
    check("async_err", err, 0);
    check("async_acks", {i_ack, d_ack}, 0);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("no_ack_after_rst", {i_ack, d_ack, mem_cs}, 0);
    end
    // fresh request after reset
    x = {8{32'h5A5A_0808}};
    i_addr = 32'h0000_081F; i_req = 1'b1; push(0, 0, x);
    serve(1, x, 0, 32'h0000_0800, '0, 1);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ext_mem_arbiter.md
Name: ext_mem_arbiter

Overview:
Shares the single external 256-bit line memory between the L1 instruction-cache refill port and the L1 data-cache refill/write-back port. It arbitrates simultaneous requests round-robin and registers the granted request onto the memory bus. It waits for the memory's ack, then returns a one-cycle ack plus line data to the winner. It sits between both L1 cache controllers and the external memory model.

Parameters:
ADDR_W, 32, byte address width (22-bit tag + 5-bit index + 5-bit offset)
LINE_W, 256, cache line / memory data width
TIMEOUT_CYC, 1023, max BUSY cycles without mem_ack before abort; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
i_req  in  1  I-cache line read request; held until i_ack
i_addr  in  ADDR_W  I-cache line address
i_ack  out  1  one-cycle completion pulse to I-cache
d_req  in  1  D-cache request; held until d_ack
d_we  in  1  D-cache 1 = write-back, 0 = refill read
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write-back line
d_ack  out  1  one-cycle completion pulse to D-cache
rdata  out  LINE_W  registered read line, valid while i_ack/d_ack is high
mem_cs  out  1  memory chip select
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address, offset bits [4:0] forced to 0
mem_wdata  out  LINE_W  memory write data
mem_data_i  in  LINE_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion pulse
err  out  1  sticky timeout flag
owner  out  1  current/last grant: 0 = I-cache, 1 = D-cache

Behaviour:
- Reset: state IDLE. i_ack, d_ack, mem_cs, mem_we, err = 0. rdata, mem_addr, mem_wdata = 0. Timeout counter = 0. owner = 1, so the first tie goes to the I-cache. Reset mid-transaction aborts the transaction immediately, with no ack.
- States: IDLE, BUSY, RESP. All outputs are registered.
- IDLE, no request: stay; mem_cs = 0.
- IDLE, exactly one request: grant that port.
- IDLE, both requests: grant the port opposite owner (round-robin).
- On grant: latch address, we and wdata into the mem_* registers; the I-cache always gets we = 0. Set owner, clear the counter, go to BUSY. mem_cs rises the cycle after the request is first sampled.
- BUSY: mem_cs = 1 and mem_* are held stable regardless of requester inputs. The counter increments each cycle.
- BUSY, mem_ack = 1: capture mem_data_i into rdata (read only; writes leave rdata unchanged). Go to RESP.
- BUSY, TIMEOUT_CYC != 0 and counter == TIMEOUT_CYC-1 with no mem_ack: set err, set rdata = 0, go to RESP. mem_ack on that same cycle wins and no error is raised.
- RESP: mem_cs = mem_we = 0. Pulse ack for exactly one cycle to owner. Go to IDLE unconditionally. Requests are not sampled in RESP, so the requester has one cycle to drop req.
- Turnaround: mem_ack at cycle m gives ack at m+1. The next grant is sampled at m+2, with mem_cs at m+3.
- mem_ack in IDLE or RESP is ignored.
- err stays set until reset.
- Counter width is clog2(TIMEOUT_CYC+1); no wrap is possible because the abort fires first.
- Requester dropping req while BUSY is a protocol violation: the transaction still completes and the ack is still issued.

Test Plan:
- I-only read: i_req=1, i_addr=0x0000_1234 -> mem_addr=0x0000_1220, mem_we=0, mem_cs one cycle later. mem_ack after 5 cycles with data 0xA5…A5 -> i_ack one cycle with rdata=0xA5…A5, d_ack=0.
- D write-back: d_req=1, d_we=1, d_addr=0x0040_0000, d_wdata=0xDEAD…BEEF -> mem_we=1 and mem_wdata equal to that line. Inputs change during BUSY -> mem_* unchanged. mem_ack -> d_ack pulse.
- Tie after reset: i_req and d_req both 1 -> I served first (owner=0). D served next, with mem_cs at m+3 of the first ack. Third tie -> I again.
- Back-to-back D only: d_req held for 3 transactions -> each is granted; owner stays 1; there is a one-cycle RESP gap each time.
- Timeout with TIMEOUT_CYC=8: no mem_ack -> RESP after exactly 8 BUSY cycles, ack with rdata=0, err=1 held. A later normal transaction keeps err=1.
- Reset mid-BUSY: assert rst low -> mem_cs=0 asynchronously, no ack, owner=1. After release the arbiter accepts a fresh request normally.
